// File: rtl/mips_cpu_harvard_dmem.sv
// rtl/mips_cpu_harvard_dmem.sv - data-memory responder for the Harvard CPU data port
//
// Serves a fast RAM region with combinational reads and single-cycle writes.
// It also serves a slow region that freezes the CPU (clk_enable = 0) for
// SLOW_LATENCY cycles, followed by one DONE cycle that returns or commits the data.
// Misaligned, unmapped or read+write requests set a sticky fault flag.
//
// Ports:
//   clk            - single clock, rising edge
//   reset          - synchronous, active-high
//   data_address   - byte address from the CPU
//   data_read      - read request
//   data_write     - write request
//   data_writedata - write data
//   data_readdata  - read data (0 when no valid read is being answered)
//   clk_enable     - CPU clock enable, 0 freezes the CPU
//   fault          - sticky bad-access flag, cleared only by reset

module mips_cpu_harvard_dmem #(
  parameter logic [31:0] RAM_BASE     = 32'h0000_1000,
  parameter int unsigned RAM_WORDS    = 256,
  parameter logic [31:0] SLOW_BASE    = 32'h0000_2000,
  parameter int unsigned SLOW_WORDS   = 64,
  parameter int unsigned SLOW_LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        clk_enable,
  output logic        fault
);

  localparam int RAM_AW  = (RAM_WORDS  > 1) ? $clog2(RAM_WORDS)  : 1;
  localparam int SLOW_AW = (SLOW_WORDS > 1) ? $clog2(SLOW_WORDS) : 1;
  localparam logic [3:0] LAT_M1 = 4'(SLOW_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       start;

  logic [SLOW_AW-1:0] lat_idx;
  logic               lat_write;
  logic [31:0]        lat_data;

  logic [31:0] ram  [RAM_WORDS];
  logic [31:0] slow [SLOW_WORDS];

  // Word offsets from each base; for addresses at or above an aligned base this
  // equals (data_address - base) >> 2.
  logic [29:0] ram_wofs, slow_wofs;
  logic        fast_hit, slow_hit;
  logic        req, bad, fast_ok, slow_ok;

  assign ram_wofs  = data_address[31:2] - RAM_BASE[31:2];
  assign slow_wofs = data_address[31:2] - SLOW_BASE[31:2];
  assign fast_hit  = (data_address >= RAM_BASE)  && (ram_wofs  < 30'(RAM_WORDS));
  assign slow_hit  = (data_address >= SLOW_BASE) && (slow_wofs < 30'(SLOW_WORDS));

  assign req     = data_read | data_write;
  assign bad     = req && ((data_read && data_write) || (data_address[1:0] != 2'b00) ||
                           !(fast_hit || slow_hit));
  assign fast_ok = req && !bad && fast_hit;
  assign slow_ok = req && !bad && !fast_hit && slow_hit;

  // Next state, stall and read data. The counter holds the stall cycles still
  // owed after the current one; the IDLE cycle that accepts the request is the
  // first stall cycle, so WAIT lasts SLOW_LATENCY-1 cycles.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    start         = 1'b0;
    clk_enable    = 1'b1;
    data_readdata = 32'h0;
    if (!reset) begin
      case (state_q)
        S_IDLE: begin
          if (slow_ok) begin
            start      = 1'b1;
            clk_enable = 1'b0;
            cnt_d      = LAT_M1;
            state_d    = (LAT_M1 == 4'd0) ? S_DONE : S_WAIT;
          end else if (fast_ok && data_read) begin
            data_readdata = ram[ram_wofs[RAM_AW-1:0]];
          end
        end
        S_WAIT: begin
          clk_enable = 1'b0;
          if (cnt_q <= 4'd1) begin
            cnt_d   = 4'd0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        S_DONE: begin
          if (!lat_write) data_readdata = slow[lat_idx];
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      fault     <= 1'b0;
      lat_idx   <= '0;
      lat_write <= 1'b0;
      lat_data  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && bad) fault <= 1'b1;
      if (start) begin
        lat_idx   <= slow_wofs[SLOW_AW-1:0];
        lat_write <= data_write;
        lat_data  <= data_writedata;
      end
    end
  end

  // Memory contents are deliberately not reset. A slow write only commits in
  // DONE, so a reset during WAIT drops it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == S_IDLE && fast_ok && data_write)
        ram[ram_wofs[RAM_AW-1:0]] <= data_writedata;
      if (state_q == S_DONE && lat_write)
        slow[lat_idx] <= lat_data;
    end
  end

endmodule

// File: tb/tb_mips_cpu_harvard_dmem.sv
// tb/tb_mips_cpu_harvard_dmem.sv - self-checking bench for mips_cpu_harvard_dmem

module tb_mips_cpu_harvard_dmem;

  localparam logic [31:0] RAM_BASE  = 32'h0000_1000;
  localparam int          RAM_WORDS = 256;
  localparam logic [31:0] SLOW_BASE = 32'h0000_2000;
  localparam int          SLOW_WORDS = 64;
  localparam int          LAT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_address = 32'h0;
  logic        data_read = 1'b0;
  logic        data_write = 1'b0;
  logic [31:0] data_writedata = 32'h0;
  logic [31:0] data_readdata;
  logic        clk_enable;
  logic        fault;

  int n_checks = 0;
  int n_fail = 0;

  mips_cpu_harvard_dmem #(
    .RAM_BASE(RAM_BASE), .RAM_WORDS(RAM_WORDS),
    .SLOW_BASE(SLOW_BASE), .SLOW_WORDS(SLOW_WORDS), .SLOW_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset), .data_address(data_address), .data_read(data_read),
    .data_write(data_write), .data_writedata(data_writedata),
    .data_readdata(data_readdata), .clk_enable(clk_enable), .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rdata;
    int          exp_stalls;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[15];

  // Reference model: word arrays plus "known" flags, and the sticky fault.
  logic [31:0] fast_m [RAM_WORDS];
  bit          fast_k [RAM_WORDS];
  logic [31:0] slow_m [SLOW_WORDS];
  bit          slow_k [SLOW_WORDS];
  bit          model_fault;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Presents one request right after a rising edge, holds it through any stall,
  // and returns the data seen in the cycle the CPU is released.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rdata,
                        output int stalls, output bit stall_rd_bad);
    data_read = rd;
    data_write = wr;
    data_address = addr;
    data_writedata = wd;
    stalls = 0;
    stall_rd_bad = 0;
    @(negedge clk);
    while (clk_enable !== 1'b1 && stalls < 40) begin
      stalls++;
      if (data_readdata !== 32'h0) stall_rd_bad = 1;
      @(negedge clk);
    end
    rdata = data_readdata;
    @(posedge clk);
    #1;
    data_read = 1'b0;
    data_write = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    data_read = 1'b0;
    data_write = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk("reset clk_enable", 32'(clk_enable), 32'h1);
      chk("reset readdata", data_readdata, 32'h0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    model_fault = 0;
    chk("reset fault", 32'(fault), 32'h0);
  endtask

  // 0 = no request, 1 = bad, 2 = fast, 3 = slow
  function automatic int classify(input logic rd, input logic wr, input logic [31:0] addr);
    longint a = longint'(addr);
    if (!rd && !wr) return 0;
    if (rd && wr) return 1;
    if (a % 4 != 0) return 1;
    if (a >= longint'(RAM_BASE) && (a - longint'(RAM_BASE)) / 4 < RAM_WORDS) return 2;
    if (a >= longint'(SLOW_BASE) && (a - longint'(SLOW_BASE)) / 4 < SLOW_WORDS) return 3;
    return 1;
  endfunction

  logic [31:0] rdata;
  int          stalls;
  bit          srb;

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 32'h1004, 32'hDEADBEEF, 32'h0,        0,   1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h1004, 32'h0,        32'hDEADBEEF, 0,   1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h1000, 32'h11111111, 32'h0,        0,   1'b0};
    vecs[3]  = '{1'b0, 1'b1, 32'h13FC, 32'h13579BDF, 32'h0,        0,   1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h13FC, 32'h0,        32'h13579BDF, 0,   1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h1000, 32'h0,        32'h11111111, 0,   1'b0};
    vecs[6]  = '{1'b0, 1'b1, 32'h2008, 32'h12345678, 32'h0,        LAT, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'h2008, 32'h0,        32'h12345678, LAT, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 32'h2000, 32'hA5A5A5A5, 32'h0,        LAT, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'h2000, 32'h0,        32'hA5A5A5A5, LAT, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'h20FC, 32'h0BADF00D, 32'h0,        LAT, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 32'h20FC, 32'h0,        32'h0BADF00D, LAT, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 32'h1004, 32'h0,        32'hDEADBEEF, 0,   1'b0};
    vecs[13] = '{1'b1, 1'b0, 32'h1002, 32'h0,        32'h0,        0,   1'b1};
    vecs[14] = '{1'b1, 1'b0, 32'h1004, 32'h0,        32'hDEADBEEF, 0,   1'b1};

    @(posedge clk);
    #1;
    do_reset(2);

    // Directed vectors, applied back to back.
    for (int i = 0; i < 15; i++) begin
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, rdata, stalls, srb);
      chk($sformatf("vec%0d readdata", i), rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d stalls", i), 32'(stalls), 32'(vecs[i].exp_stalls));
      chk($sformatf("vec%0d stall readdata", i), 32'(srb), 32'h0);
      chk($sformatf("vec%0d fault", i), 32'(fault), 32'(vecs[i].exp_fault));
    end

    // Read and write both high: fault, no write, no stall.
    do_reset(1);
    access(1'b1, 1'b1, 32'h1004, 32'hFFFFFFFF, rdata, stalls, srb);
    chk("both readdata", rdata, 32'h0);
    chk("both stalls", 32'(stalls), 32'h0);
    chk("both fault", 32'(fault), 32'h1);
    access(1'b1, 1'b0, 32'h1004, 32'h0, rdata, stalls, srb);
    chk("both ram unchanged", rdata, 32'hDEADBEEF);

    // Unmapped write after reset.
    do_reset(1);
    access(1'b0, 1'b1, 32'h8000, 32'h00000055, rdata, stalls, srb);
    chk("unmapped stalls", 32'(stalls), 32'h0);
    chk("unmapped fault", 32'(fault), 32'h1);
    access(1'b1, 1'b0, 32'h1004, 32'h0, rdata, stalls, srb);
    chk("unmapped ram 1004", rdata, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'h13FC, 32'h0, rdata, stalls, srb);
    chk("unmapped ram 13fc", rdata, 32'h13579BDF);

    // One word past each region end is unmapped.
    do_reset(1);
    access(1'b0, 1'b1, 32'h1400, 32'h1, rdata, stalls, srb);
    chk("ram end+1 fault", 32'(fault), 32'h1);
    do_reset(1);
    access(1'b1, 1'b0, 32'h2100, 32'h0, rdata, stalls, srb);
    chk("slow end+1 stalls", 32'(stalls), 32'h0);
    chk("slow end+1 readdata", rdata, 32'h0);
    chk("slow end+1 fault", 32'(fault), 32'h1);

    // Reset during the second stall cycle of a slow write drops the write.
    do_reset(1);
    access(1'b0, 1'b1, 32'h2004, 32'hCAFEF00D, rdata, stalls, srb);
    chk("midwait setup stalls", 32'(stalls), 32'(LAT));
    data_write = 1'b1;
    data_address = 32'h2004;
    data_writedata = 32'h1;
    @(negedge clk);
    chk("midwait stall1 clk_enable", 32'(clk_enable), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("midwait reset clk_enable", 32'(clk_enable), 32'h1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    data_write = 1'b0;
    chk("midwait fault", 32'(fault), 32'h0);
    access(1'b1, 1'b0, 32'h2004, 32'h0, rdata, stalls, srb);
    chk("midwait old value", rdata, 32'hCAFEF00D);
    chk("midwait read stalls", 32'(stalls), 32'(LAT));
    chk("midwait fault after", 32'(fault), 32'h0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < RAM_WORDS; i++) fast_k[i] = 0;
    for (int i = 0; i < SLOW_WORDS; i++) slow_k[i] = 0;
    do_reset(1);
    for (int n = 0; n < 400; n++) begin
      int k;
      int cls;
      int idx;
      logic rd, wr;
      logic [31:0] addr, wd, exp;
      bit known;
      if (n % 80 == 79) do_reset(1);
      k = int'($urandom_range(0, 19));
      wd = $urandom;
      rd = $urandom_range(0, 1) == 1;
      wr = !rd;
      idx = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 15));
      if (k == 0) addr = RAM_BASE + 32'($urandom_range(0, 255) * 4 + $urandom_range(1, 3));
      else if (k == 1) addr = 32'h8000 + 32'($urandom_range(0, 1023) * 4);
      else if (k == 2) begin
        rd = 1'b1;
        wr = 1'b1;
        addr = RAM_BASE + 32'($urandom_range(0, 15) * 4);
      end else if (k <= 10) addr = RAM_BASE + 32'(((idx < 0) ? RAM_WORDS - 1 : idx) * 4);
      else if (k <= 18) addr = SLOW_BASE + 32'(((idx < 0) ? SLOW_WORDS - 1 : idx % 8) * 4);
      else begin
        rd = 1'b0;
        wr = 1'b0;
        addr = $urandom;
      end
      cls = classify(rd, wr, addr);
      exp = 32'h0;
      known = 1;
      if (cls == 2) begin
        idx = int'((addr - RAM_BASE) / 4);
        if (rd) begin known = fast_k[idx]; exp = fast_m[idx]; end
      end else if (cls == 3) begin
        idx = int'((addr - SLOW_BASE) / 4);
        if (rd) begin known = slow_k[idx]; exp = slow_m[idx]; end
      end
      access(rd, wr, addr, wd, rdata, stalls, srb);
      if (known) chk($sformatf("rand%0d readdata @%h", n, addr), rdata, exp);
      chk($sformatf("rand%0d stalls @%h", n, addr), 32'(stalls), (cls == 3) ? 32'(LAT) : 32'h0);
      if (cls == 3) chk($sformatf("rand%0d stall readdata", n), 32'(srb), 32'h0);
      if (cls == 1) model_fault = 1;
      if (cls == 2 && wr) begin fast_m[idx] = wd; fast_k[idx] = 1; end
      if (cls == 3 && wr) begin slow_m[idx] = wd; slow_k[idx] = 1; end
      chk($sformatf("rand%0d fault", n), 32'(fault), 32'(model_fault));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
